fp_add_result_buffer: RTL and testbench
=======================================

Name: fp_add_result_buffer

Overview:
- Downstream stage of the combinational single-precision FP adder.
- Captures each adder result (fp_result, overflow, underflow) with a tag into a DEPTH-entry FIFO and presents it to the consumer over a valid/ready interface.
- Derives per-result exception flags and keeps a sticky flag register (fflags) that is updated when results are committed.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- TAG_W, 4, width of the caller tag carried alongside each result.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, adder result present this cycle.
- in_ready, output, 1, buffer can accept this cycle.
- in_result, input, 32, adder fp_result.
- in_overflow, input, 1, adder overflow flag.
- in_underflow, input, 1, adder underflow flag.
- in_tag, input, TAG_W, caller tag.
- out_valid, output, 1, head entry valid.
- out_ready, input, 1, consumer accepts the head entry.
- out_result, output, 32, head result.
- out_flags, output, 3, head flags {nan, overflow, underflow}.
- out_tag, output, TAG_W, head tag.
- fflags, output, 3, sticky {nan, overflow, underflow}.
- fflags_clr, input, 1, clear sticky flags.
- count, output, $clog2(DEPTH+1), occupied entries.

Behaviour:
- Reset (rst_n low at clk edge):
  - count=0, read/write pointers=0, fflags=0, out_valid=0.
  - out_result/out_flags/out_tag = 0.
  - in_ready=1 on the cycle after reset.
  - Reset mid-operation discards all entries; no output handshake completes in the reset cycle.
- Enqueue:
  - Fires when in_valid && in_ready.
  - Stored entry = {in_result, nan, in_overflow, in_underflow, in_tag}.
  - nan = (in_result[30:23]==8'hFF) && |in_result[22:0].
- Dequeue: fires when out_valid && out_ready; advances the read pointer.
- Ready and valid generation:
  - in_ready = (count != DEPTH), registered from count.
  - No full-bypass: when full, an enqueue is not accepted even if a dequeue occurs in the same cycle.
  - out_valid = (count != 0).
  - Outputs are driven from the head entry, so latency is 1 cycle: an entry accepted at edge N is visible at out_* after edge N.
  - No combinational in→out path.
- Simultaneous enqueue and dequeue when not full and not empty: count is unchanged and both pointers advance.
- Empty: an enqueue makes out_valid=1 on the next cycle. out_ready while empty has no effect.
- Pointers wrap modulo DEPTH. count saturates by construction, since in_ready gates enqueue and out_valid gates dequeue.
- out_* hold stable while out_valid && !out_ready.
- Sticky flags:
  - On a dequeue edge: fflags <= (fflags_clr ? 0 : fflags) | head out_flags.
  - With no dequeue: fflags <= fflags_clr ? 0 : fflags.
  - When clear and commit coincide, the committed flags survive.
- Flags are taken verbatim from the adder. The buffer never recomputes overflow/underflow.

Optional Feature:
- Macro: FP_ADD_BUF_CANON_NAN_EN.
- Defined:
  - On enqueue, any NaN in_result (exp 8'hFF, nonzero mantissa) is stored as canonical 32'h7FC00000.
  - The nan flag is still set.
  - Infinities (mantissa 0) are untouched.
- Undefined: in_result is stored bit-exact.

Test Plan:
- Reset/empty: hold rst_n=0 for 2 cycles, then release → count=0, out_valid=0, in_ready=1, fflags=3'b000.
- Single pass: enqueue in_result=32'h40400000, tag=3, flags 0 with out_ready=1 → next cycle out_valid=1, out_result=32'h40400000, out_tag=3, out_flags=000; the cycle after, count=0 and fflags=000.
- Fill/backpressure: out_ready=0, offer 5 results 32'h3F800000..32'h3F800004 → first 4 accepted, in_ready=0, count=4; raise out_ready → outputs appear in order 3F800000..3F800003, and in_ready=1 one cycle after the first dequeue.
- Simultaneous push/pop at count=2 → count stays 2 and ordering is preserved.
- Sticky flags: commit an entry with in_overflow=1, then an entry with in_result=32'h7F800001 → fflags=3'b110. Assert fflags_clr together with committing an entry carrying in_underflow=1 → fflags=3'b001.
- Canonical NaN, with FP_ADD_BUF_CANON_NAN_EN defined: enqueue 32'hFFC12345 → out_result=32'h7FC00000, out_flags=3'b100. Without the macro → out_result=32'hFFC12345. Enqueue 32'h7F800000 → passed unchanged, nan=0 in both builds.

Source files
------------

// File: rtl/fp_add_result_buffer.sv
// fp_add_result_buffer: DEPTH-entry result FIFO behind the combinational FP adder.
// Captures {result, nan, overflow, underflow, tag}, presents the head entry over
// valid/ready, and accumulates sticky exception flags as results are committed.
// Optional build macro: FP_ADD_BUF_CANON_NAN_EN (store NaNs as canonical 32'h7FC00000).
module fp_add_result_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_result,
    input  logic                       in_overflow,
    input  logic                       in_underflow,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_result,
    output logic [2:0]                 out_flags,
    output logic [TAG_W-1:0]           out_tag,
    output logic [2:0]                 fflags,
    input  logic                       fflags_clr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    // One buffered result; flags ordered {nan, overflow, underflow}
    typedef struct packed {
        logic [31:0]      result;
        logic [2:0]       flags;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    entry_t             head_q, head_d;
    logic [2:0]         fflags_q, fflags_d;

    logic               push;
    logic               pop;
    logic               in_nan;
    entry_t             in_entry;

    // Classify the incoming result and form the entry to store
    always_comb begin
        in_nan          = (&in_result[30:23]) && (|in_result[22:0]);
        in_entry        = '0;
        in_entry.flags  = {in_nan, in_overflow, in_underflow};
        in_entry.tag    = in_tag;
`ifdef FP_ADD_BUF_CANON_NAN_EN
        in_entry.result = in_nan ? CANON_NAN : in_result;
`else
        in_entry.result = in_result;
`endif
    end

    // Next-state: storage, pointers, occupancy, registered handshakes, head, sticky flags
    always_comb begin
        push        = in_valid && in_ready_q;
        pop         = out_valid_q && out_ready;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = in_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        in_ready_d  = (count_d != CNT_W'(DEPTH));
        out_valid_d = (count_d != CNT_W'(0));
        head_d      = mem_d[rd_ptr_d];

        // A commit in the same cycle as a clear still lands its flags
        fflags_d    = (fflags_clr ? 3'b000 : fflags_q) | (pop ? head_q.flags : 3'b000);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_q      <= '0;
            fflags_q    <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
            fflags_q    <= fflags_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = head_q.result;
    assign out_flags  = head_q.flags;
    assign out_tag    = head_q.tag;
    assign fflags     = fflags_q;
    assign count      = count_q;

endmodule

// File: tb/tb_fp_add_result_buffer.sv
// Directed bench for fp_add_result_buffer (DEPTH=4, TAG_W=4), hand-computed expectations.
module tb_fp_add_result_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_overflow;
    logic        in_underflow;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;
    logic [3:0]  out_tag;
    logic [2:0]  fflags;
    logic        fflags_clr;
    logic [2:0]  count;

    int tests;
    int fails;

    fp_add_result_buffer #(.DEPTH(4), .TAG_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .out_tag      (out_tag),
        .fflags       (fflags),
        .fflags_clr   (fflags_clr),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_nan;
        tests        = 0;
        fails        = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_result    = '0;
        in_overflow  = 1'b0;
        in_underflow = 1'b0;
        in_tag       = '0;
        out_ready    = 1'b0;
        fflags_clr   = 1'b0;

        // Reset / empty
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_count",     32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_fflags",    32'(fflags), 32'd0);
        chk("rst_out_result", out_result, 32'd0);

        // Single pass
        in_valid  = 1'b1;
        in_result = 32'h4040_0000;
        in_tag    = 4'd3;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("sp_out_valid",  32'(out_valid), 32'd1);
        chk("sp_out_result", out_result, 32'h4040_0000);
        chk("sp_out_tag",    32'(out_tag), 32'd3);
        chk("sp_out_flags",  32'(out_flags), 32'd0);
        tick();
        chk("sp_count",  32'(count), 32'd0);
        chk("sp_valid0", 32'(out_valid), 32'd0);
        chk("sp_fflags", 32'(fflags), 32'd0);

        // Fill with backpressure: offer 5, accept 4
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_result = 32'h3F80_0000 + 32'(i);
            in_tag    = 4'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("fill_count",    32'(count), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_hold",     out_result, 32'h3F80_0000);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_result", out_result, 32'h3F80_0000 + 32'(i));
            chk("drain_tag",    32'(out_tag), 32'(i));
            tick();
            if (i == 0) chk("drain_in_ready", 32'(in_ready), 32'd1);
        end
        chk("drain_count", 32'(count), 32'd0);

        // Simultaneous push/pop at count=2
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_result = 32'h4100_0000; in_tag = 4'd1; tick();
        in_result = 32'h4110_0000; in_tag = 4'd2; tick();
        chk("pp_count_before", 32'(count), 32'd2);
        in_result = 32'h4120_0000; in_tag = 4'd3;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("pp_count_after", 32'(count), 32'd2);
        chk("pp_head1", out_result, 32'h4110_0000);
        tick();
        chk("pp_head2", out_result, 32'h4120_0000);
        chk("pp_tag2",  32'(out_tag), 32'd3);
        tick();
        chk("pp_count_end", 32'(count), 32'd0);

        // Sticky flags: overflow commit, then NaN commit
        in_valid    = 1'b1;
        in_result   = 32'h3F80_0000;
        in_overflow = 1'b1;
        in_tag      = 4'd5;
        tick();
        in_overflow = 1'b0;
        in_result   = 32'h7F80_0001;
        in_tag      = 4'd6;
        tick();
        in_valid = 1'b0;
        chk("st_nan_flags", 32'(out_flags), 32'b100);
        chk("st_fflags_ov", 32'(fflags), 32'b010);
        tick();
        chk("st_fflags_110", 32'(fflags), 32'b110);
        // Clear coincides with underflow commit
        in_valid     = 1'b1;
        in_result    = 32'h0000_0001;
        in_underflow = 1'b1;
        tick();
        in_valid     = 1'b0;
        in_underflow = 1'b0;
        fflags_clr   = 1'b1;
        tick();
        fflags_clr = 1'b0;
        chk("st_clr_commit", 32'(fflags), 32'b001);
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        chk("st_clr_only", 32'(fflags), 32'b000);

        // NaN canonicalisation and infinity pass-through
`ifdef FP_ADD_BUF_CANON_NAN_EN
        exp_nan = 32'h7FC0_0000;
`else
        exp_nan = 32'hFFC1_2345;
`endif
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_result = 32'hFFC1_2345;
        tick();
        chk("nan_result", out_result, exp_nan);
        chk("nan_flags",  32'(out_flags), 32'b100);
        out_ready = 1'b1;
        in_result = 32'h7F80_0000;
        tick();
        in_valid = 1'b0;
        chk("inf_result", out_result, 32'h7F80_0000);
        chk("inf_flags",  32'(out_flags), 32'b000);
        chk("nan_fflags", 32'(fflags), 32'b100);
        tick();
        chk("inf_count", 32'(count), 32'd0);

        // Reset mid-operation discards entries
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_result = 32'h4000_0000;
        tick();
        tick();
        in_valid = 1'b0;
        chk("mid_count_pre", 32'(count), 32'd2);
        rst_n     = 1'b0;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        chk("mid_count",     32'(count), 32'd0);
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_fflags",    32'(fflags), 32'd0);
        chk("mid_in_ready",  32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
